// File: rtl/sdram_upload_bridge.sv
// rtl/sdram_upload_bridge.sv - serves 16-bit hps_io upload reads from a 32-bit SDRAM channel
//
// Purpose:
//   Answers ioctl upload reads (one halfword per strobe) from SDRAM. Each 32-bit
//   word fetched is cached, so the second halfword of a word is served without
//   another SDRAM access. ioctl_wait stalls the HPS while a fetch is in flight, and
//   a watchdog aborts a fetch whose sdram_ready never arrives.
//
// Ports:
//   clk1x          in   1   system clock
//   reset_n        in   1   asynchronous active-low reset
//   upload_active  in   1   upload in progress; low flushes the cache and aborts fetches
//   ioctl_addr     in   27  byte address of the requested halfword (bit 0 ignored)
//   ioctl_rd       in   1   single-cycle read strobe
//   ioctl_din      out  16  halfword returned to hps_io
//   ioctl_wait     out  1   stall while a fetch is outstanding
//   sdram_req      out  1   single-cycle read request
//   sdram_rnw      out  1   tied high (read only)
//   sdram_addr     out  27  word-aligned SDRAM byte address
//   sdram_dout     in   32  SDRAM read data, valid with sdram_ready
//   sdram_ready    in   1   single-cycle completion pulse
//   timeout_err    out  1   sticky watchdog flag, cleared when upload_active falls

module sdram_upload_bridge #(
    parameter logic [26:0] BASE_ADDR = 27'd1048576,
    parameter logic [9:0]  TIMEOUT   = 10'd1023,
    parameter logic [15:0] ERR_DATA  = 16'hDEAD
) (
    input  logic        clk1x,
    input  logic        reset_n,
    input  logic        upload_active,
    input  logic [26:0] ioctl_addr,
    input  logic        ioctl_rd,
    output logic [15:0] ioctl_din,
    output logic        ioctl_wait,
    output logic        sdram_req,
    output logic        sdram_rnw,
    output logic [26:0] sdram_addr,
    input  logic [31:0] sdram_dout,
    input  logic        sdram_ready,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [26:1]  addr_q, addr_d;
    logic [31:0]  cache_q, cache_d;
    logic [24:0]  tag_q, tag_d;
    logic         valid_q, valid_d;
    logic [9:0]   wdog_q, wdog_d;
    logic [15:0]  din_q, din_d;
    logic         wait_q, wait_d;
    logic         req_q, req_d;
    logic [26:0]  sdram_addr_q, sdram_addr_d;
    logic         err_q, err_d;

    logic         hit;
    logic         rd_fire;
    logic         miss_fire;
    logic [24:0]  fetch_word;
    logic         unused_addr_bit0;

    // Halfword lane of a cached word: addr[1] picks the upper half.
    function automatic logic [15:0] pick_half(input logic [31:0] w, input logic hi);
        return hi ? w[31:16] : w[15:0];
    endfunction

    assign unused_addr_bit0 = ioctl_addr[0];

    assign hit       = valid_q && (tag_q == ioctl_addr[26:2]);
    assign rd_fire   = ioctl_rd && upload_active && (state_q == ST_IDLE);
    assign miss_fire = rd_fire && !hit;

    // The add is done on word addresses so the result is word aligned by construction
    // and wraps within 27 bits.
    assign fetch_word = addr_q[26:2] + BASE_ADDR[26:2];

    // The stall must be visible in the strobe cycle itself, before the flop catches up.
    assign ioctl_wait  = wait_q | miss_fire;
    assign ioctl_din   = din_q;
    assign sdram_req   = req_q;
    assign sdram_rnw   = 1'b1;
    assign sdram_addr  = sdram_addr_q;
    assign timeout_err = err_q;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        cache_d      = cache_q;
        tag_d        = tag_q;
        valid_d      = valid_q;
        wdog_d       = wdog_q;
        din_d        = din_q;
        wait_d       = wait_q;
        req_d        = 1'b0;
        sdram_addr_d = sdram_addr_q;
        err_d        = err_q;

        if (!upload_active) begin
            // Flush: abandon any fetch; a ready pulse still in flight lands in IDLE
            // and is dropped there.
            state_d = ST_IDLE;
            valid_d = 1'b0;
            err_d   = 1'b0;
            wait_d  = 1'b0;
            wdog_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rd_fire) begin
                        if (hit) begin
                            din_d = pick_half(cache_q, ioctl_addr[1]);
                        end else begin
                            addr_d  = ioctl_addr[26:1];
                            wait_d  = 1'b1;
                            state_d = ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    req_d        = 1'b1;
                    sdram_addr_d = {fetch_word, 2'b00};
                    wdog_d       = '0;
                    state_d      = ST_WAIT;
                end
                ST_WAIT: begin
                    if (sdram_ready) begin
                        cache_d = sdram_dout;
                        tag_d   = addr_q[26:2];
                        valid_d = 1'b1;
                        din_d   = pick_half(sdram_dout, addr_q[1]);
                        wait_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else if (wdog_q == TIMEOUT) begin
                        din_d   = ERR_DATA;
                        err_d   = 1'b1;
                        valid_d = 1'b0;
                        wait_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        wdog_d = wdog_q + 10'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    wait_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk1x or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            cache_q      <= '0;
            tag_q        <= '0;
            valid_q      <= 1'b0;
            wdog_q       <= '0;
            din_q        <= '0;
            wait_q       <= 1'b0;
            req_q        <= 1'b0;
            sdram_addr_q <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            cache_q      <= cache_d;
            tag_q        <= tag_d;
            valid_q      <= valid_d;
            wdog_q       <= wdog_d;
            din_q        <= din_d;
            wait_q       <= wait_d;
            req_q        <= req_d;
            sdram_addr_q <= sdram_addr_d;
            err_q        <= err_d;
        end
    end

endmodule

// File: tb/tb_sdram_upload_bridge.sv
// tb/tb_sdram_upload_bridge.sv - directed self-checking bench for sdram_upload_bridge

module tb_sdram_upload_bridge;

    logic        clk1x;
    logic        reset_n;
    logic        upload_active;
    logic [26:0] ioctl_addr;
    logic        ioctl_rd;
    logic [15:0] ioctl_din;
    logic        ioctl_wait;
    logic        sdram_req;
    logic        sdram_rnw;
    logic [26:0] sdram_addr;
    logic [31:0] sdram_dout;
    logic        sdram_ready;
    logic        timeout_err;

    int checks;
    int failures;
    int cyc;
    int req_count;
    int ready_cyc;
    int strobe_cyc;
    int rel_cyc;
    logic [26:0] last_req_addr;
    int lat;
    bit resp_en;
    int resp_cnt;
    logic [26:0] resp_addr;
    bit manual_pulse;
    logic [31:0] manual_data;

    sdram_upload_bridge dut (
        .clk1x         (clk1x),
        .reset_n       (reset_n),
        .upload_active (upload_active),
        .ioctl_addr    (ioctl_addr),
        .ioctl_rd      (ioctl_rd),
        .ioctl_din     (ioctl_din),
        .ioctl_wait    (ioctl_wait),
        .sdram_req     (sdram_req),
        .sdram_rnw     (sdram_rnw),
        .sdram_addr    (sdram_addr),
        .sdram_dout    (sdram_dout),
        .sdram_ready   (sdram_ready),
        .timeout_err   (timeout_err)
    );

    initial clk1x = 1'b0;
    always #5 clk1x = ~clk1x;

    always @(posedge clk1x) cyc++;

    function automatic logic [31:0] mem_word(input logic [26:0] a);
        if (a == 27'h100000) return 32'hAABBCCDD;
        if (a == 27'h100004) return 32'h11223344;
        return {a[15:0], ~a[15:0]};
    endfunction

    // SDRAM channel model: answers each request after lat cycles unless disabled.
    always @(posedge clk1x) begin
        #1;
        sdram_ready = 1'b0;
        if (manual_pulse) begin
            sdram_ready  = 1'b1;
            sdram_dout   = manual_data;
            manual_pulse = 1'b0;
            ready_cyc    = cyc;
        end else if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
                sdram_ready = 1'b1;
                sdram_dout  = mem_word(resp_addr);
                ready_cyc   = cyc;
            end
        end
        if (sdram_req) begin
            req_count++;
            last_req_addr = sdram_addr;
            if (resp_en) begin
                resp_cnt  = lat;
                resp_addr = sdram_addr;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic strobe(input logic [26:0] a, output logic w);
        @(posedge clk1x);
        #1;
        ioctl_addr = a;
        ioctl_rd   = 1'b1;
        strobe_cyc = cyc;
        @(negedge clk1x);
        w = ioctl_wait;
        @(posedge clk1x);
        #1;
        ioctl_rd = 1'b0;
    endtask

    task automatic wait_release(input int max);
        int n;
        n = 0;
        @(negedge clk1x);
        while (ioctl_wait && n < max) begin
            @(negedge clk1x);
            n++;
        end
        rel_cyc = cyc;
        check("wait_released", {31'd0, ioctl_wait}, 32'd0);
    endtask

    task automatic miss_read(input string tag, input logic [26:0] a, input logic [15:0] exp_din,
                             input logic [26:0] exp_req, input int max, input int exp_lat);
        int rc0;
        logic w;
        rc0 = req_count;
        strobe(a, w);
        check($sformatf("%s_wait_comb", tag), {31'd0, w}, 32'd1);
        wait_release(max);
        check($sformatf("%s_din", tag), {16'd0, ioctl_din}, {16'd0, exp_din});
        check($sformatf("%s_reqs", tag), req_count, rc0 + 1);
        check($sformatf("%s_req_addr", tag), {5'd0, last_req_addr}, {5'd0, exp_req});
        check($sformatf("%s_latency", tag), rel_cyc - strobe_cyc, exp_lat);
    endtask

    task automatic hit_read(input string tag, input logic [26:0] a, input logic [15:0] exp_din);
        int rc0;
        logic w;
        rc0 = req_count;
        strobe(a, w);
        check($sformatf("%s_wait_comb", tag), {31'd0, w}, 32'd0);
        @(negedge clk1x);
        check($sformatf("%s_din", tag), {16'd0, ioctl_din}, {16'd0, exp_din});
        check($sformatf("%s_wait", tag), {31'd0, ioctl_wait}, 32'd0);
        check($sformatf("%s_noreq", tag), req_count, rc0);
    endtask

    initial begin
        logic w;
        int rc0;
        checks        = 0;
        failures      = 0;
        req_count     = 0;
        resp_cnt      = 0;
        resp_en       = 1'b1;
        lat           = 1;
        manual_pulse  = 1'b0;
        manual_data   = '0;
        reset_n       = 1'b0;
        upload_active = 1'b0;
        ioctl_addr    = '0;
        ioctl_rd      = 1'b0;
        sdram_dout    = '0;
        sdram_ready   = 1'b0;

        repeat (3) @(negedge clk1x);
        check("rst_din", {16'd0, ioctl_din}, 32'd0);
        check("rst_wait", {31'd0, ioctl_wait}, 32'd0);
        check("rst_req", {31'd0, sdram_req}, 32'd0);
        check("rst_addr", {5'd0, sdram_addr}, 32'd0);
        check("rst_err", {31'd0, timeout_err}, 32'd0);
        check("rnw", {31'd0, sdram_rnw}, 32'd1);
        reset_n = 1'b1;
        upload_active = 1'b1;
        repeat (2) @(negedge clk1x);

        // Sequential read: one fetch serves both halves.
        miss_read("seq0", 27'd0, 16'hCCDD, 27'h100000, 50, 4);
        hit_read("seq2", 27'd2, 16'hAABB);
        check("seq_total_reqs", req_count, 1);

        // Miss after hit; release one cycle after ready.
        miss_read("seq4", 27'd4, 16'h3344, 27'h100004, 50, 4);
        check("ready_to_release", rel_cyc - ready_cyc, 1);

        // Out-of-order on a cold cache.
        upload_active = 1'b0;
        repeat (2) @(negedge clk1x);
        upload_active = 1'b1;
        miss_read("ooo6", 27'd6, 16'h1122, 27'h100004, 50, 4);
        hit_read("ooo4", 27'd4, 16'h3344);

        // Timeout: no ready ever comes back.
        resp_en = 1'b0;
        miss_read("tmo", 27'd0, 16'hDEAD, 27'h100000, 1100, 1026);
        check("tmo_err", {31'd0, timeout_err}, 32'd1);
        manual_data  = 32'h5555AAAA;
        manual_pulse = 1'b1;
        repeat (3) @(negedge clk1x);
        check("late_ready_din", {16'd0, ioctl_din}, 32'h0000DEAD);
        check("late_ready_wait", {31'd0, ioctl_wait}, 32'd0);
        resp_en = 1'b1;
        // Timeout invalidated the cache, so word 1 must be fetched again.
        miss_read("tmo_refetch", 27'd4, 16'h3344, 27'h100004, 50, 4);
        check("err_sticky", {31'd0, timeout_err}, 32'd1);
        upload_active = 1'b0;
        @(negedge clk1x);
        check("err_cleared", {31'd0, timeout_err}, 32'd0);
        upload_active = 1'b1;

        // Abort a fetch by dropping upload_active during WAIT.
        lat = 5;
        rc0 = req_count;
        strobe(27'd8, w);
        check("abort_wait_comb", {31'd0, w}, 32'd1);
        @(posedge clk1x);
        #1;
        upload_active = 1'b0;
        @(negedge clk1x);
        @(negedge clk1x);
        check("abort_wait_low", {31'd0, ioctl_wait}, 32'd0);
        check("abort_reqs", req_count, rc0 + 1);
        repeat (8) @(negedge clk1x);
        check("abort_din_hold", {16'd0, ioctl_din}, 32'h00003344);
        upload_active = 1'b1;
        lat = 1;
        miss_read("abort_rd2", 27'd2, 16'hAABB, 27'h100000, 50, 4);

        // Asynchronous reset in the middle of a fetch.
        lat = 20;
        strobe(27'h10, w);
        repeat (3) @(negedge clk1x);
        check("pre_rst_wait", {31'd0, ioctl_wait}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_wait", {31'd0, ioctl_wait}, 32'd0);
        check("arst_req", {31'd0, sdram_req}, 32'd0);
        check("arst_addr", {5'd0, sdram_addr}, 32'd0);
        check("arst_din", {16'd0, ioctl_din}, 32'd0);
        check("arst_err", {31'd0, timeout_err}, 32'd0);
        rc0 = req_count;
        repeat (25) @(negedge clk1x);
        reset_n = 1'b1;
        repeat (5) @(negedge clk1x);
        check("no_reissue", req_count, rc0);
        lat = 1;
        miss_read("post_rst", 27'd0, 16'hCCDD, 27'h100000, 50, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
